// File: rtl/dbg_bridge_pkg.sv
// rtl/dbg_bridge_pkg.sv - shared opcodes, reply bytes and FSM states for the UART debug bridge
package dbg_bridge_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4,
    ST_ERR  = 3'd5
  } bridge_state_e;

endpackage

// File: rtl/dbg_byte_tx.sv
// rtl/dbg_byte_tx.sv - response serializer: sends 1..4 bytes LSB first over the UART we/wait handshake
module dbg_byte_tx (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic [2:0]  load_len_i,
  input  logic        uart_dat_wait_i,
  output logic        uart_dat_we_o,
  output logic [7:0]  uart_dat_di_o,
  output logic        done_o
);

  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic        armed_q, armed_d;
  logic        we_q, we_d;
  logic [7:0]  di_q, di_d;
  logic        accept;

  assign accept        = we_q && !uart_dat_wait_i;
  assign done_o        = accept && (cnt_q == last_q);
  assign uart_dat_we_o = we_q;
  assign uart_dat_di_o = di_q;

  // A load only arms the sender; the first byte goes out one edge later.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    armed_d = armed_q;
    we_d    = we_q;
    di_d    = di_q;
    if (load_i) begin
      shreg_d = load_data_i;
      cnt_d   = 2'd0;
      last_d  = 2'(load_len_i - 3'd1);
      armed_d = 1'b1;
    end else if (armed_q) begin
      armed_d = 1'b0;
      we_d    = 1'b1;
      di_d    = shreg_q[7:0];
    end else if (accept) begin
      if (cnt_q == last_q) begin
        we_d = 1'b0;
      end else begin
        cnt_d   = cnt_q + 2'd1;
        shreg_d = {8'h00, shreg_q[31:8]};
        di_d    = shreg_q[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      armed_q <= 1'b0;
      we_q    <= 1'b0;
      di_q    <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      armed_q <= armed_d;
      we_q    <= we_d;
      di_q    <= di_d;
    end
  end

endmodule

// File: rtl/uart_dbg_bridge.sv
// rtl/uart_dbg_bridge.sv - parses UART read/write word commands and runs one bus transaction per command
module uart_dbg_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_dat_valid,
  input  logic [7:0]  uart_dat_do,
  output logic        uart_dat_re,
  output logic        uart_dat_we,
  output logic [7:0]  uart_dat_di,
  input  logic        uart_dat_wait,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  bridge_state_e state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          is_write_q, is_write_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          is_op, last_byte, tmo_hit;
  logic          tx_load, tx_done;
  logic [31:0]   tx_data;
  logic [2:0]    tx_len;

  assign is_op     = (uart_dat_do == OP_WRITE) || (uart_dat_do == OP_READ);
  assign last_byte = (cnt_q == 2'd3);
  assign tmo_hit   = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // A byte arriving in the same cycle as the timeout still counts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (uart_dat_valid) state_d = is_op ? ST_ADDR : ST_ERR;
      ST_ADDR: begin
        if (uart_dat_valid) begin
          if (last_byte) state_d = is_write_q ? ST_DATA : ST_BUS;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (uart_dat_valid) begin
          if (last_byte) state_d = ST_BUS;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS:          if (mem_ready) state_d = ST_RESP;
      ST_RESP, ST_ERR: if (tx_done)   state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    uart_dat_re = 1'b0;
    tx_load     = 1'b0;
    tx_data     = '0;
    tx_len      = 3'd1;
    unique case (state_q)
      ST_IDLE: begin
        uart_dat_re = uart_dat_valid;
        if (uart_dat_valid && !is_op) begin
          tx_load = 1'b1;
          tx_data = {24'h0, RSP_ERR};
        end
      end
      ST_ADDR, ST_DATA: uart_dat_re = uart_dat_valid;
      ST_BUS: begin
        if (mem_ready) begin
          tx_load = 1'b1;
          tx_data = is_write_q ? {24'h0, RSP_ACK} : mem_rdata;
          tx_len  = is_write_q ? 3'd1 : 3'd4;
        end
      end
      default: ;
    endcase
  end

  assign mem_valid = (state_q == ST_BUS);
  assign busy      = (state_q != ST_IDLE);
  assign mem_addr  = addr_q & 32'hFFFF_FFFC;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  // Fields arrive LSB first, so each byte shifts in from the top.
  always_comb begin
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    is_write_d = is_write_q;
    wstrb_d    = wstrb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    if (state_d != state_q)  cnt_d = 2'd0;
    else if (uart_dat_re)    cnt_d = cnt_q + 2'd1;

    if ((state_d != state_q) || uart_dat_re ||
        !((state_q == ST_ADDR) || (state_q == ST_DATA)))
      tmo_d = '0;
    else
      tmo_d = tmo_q + 1'b1;

    if ((state_q == ST_IDLE) && uart_dat_re && is_op) begin
      is_write_d = (uart_dat_do == OP_WRITE);
      wstrb_d    = (uart_dat_do == OP_WRITE) ? 4'hF : 4'h0;
    end
    if ((state_q == ST_ADDR) && uart_dat_re) addr_d  = {uart_dat_do, addr_q[31:8]};
    if ((state_q == ST_DATA) && uart_dat_re) wdata_d = {uart_dat_do, wdata_q[31:8]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      tmo_q      <= '0;
      is_write_q <= 1'b0;
      wstrb_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      is_write_q <= is_write_d;
      wstrb_q    <= wstrb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  dbg_byte_tx u_tx (
    .clk            (clk),
    .resetn         (resetn),
    .load_i         (tx_load),
    .load_data_i    (tx_data),
    .load_len_i     (tx_len),
    .uart_dat_wait_i(uart_dat_wait),
    .uart_dat_we_o  (uart_dat_we),
    .uart_dat_di_o  (uart_dat_di),
    .done_o         (tx_done)
  );

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// tb/tb_uart_dbg_bridge.sv - directed vector bench for uart_dbg_bridge
module tb_uart_dbg_bridge;

  logic        clk, resetn;
  logic        uart_dat_valid;
  logic [7:0]  uart_dat_do;
  logic        uart_dat_re, uart_dat_we, uart_dat_wait;
  logic [7:0]  uart_dat_di;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_dbg_bridge #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .resetn(resetn),
    .uart_dat_valid(uart_dat_valid), .uart_dat_do(uart_dat_do), .uart_dat_re(uart_dat_re),
    .uart_dat_we(uart_dat_we), .uart_dat_di(uart_dat_di), .uart_dat_wait(uart_dat_wait),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          n;
    logic [71:0] bytes;
    logic [31:0] rdata;
    int          swait;
    int          twait;
    int          nbus;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  estrb;
    int          vcyc;
    int          rlen;
    logic [31:0] reply;
  } vec_t;

  vec_t vecs [6];

  // bus slave model
  int          slave_wait = 0;
  int          slave_cnt = 0;
  logic [31:0] slave_rdata = '0;
  int          valid_cycles = 0;
  int          bus_n = 0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid) valid_cycles++;
      if (mem_valid && !mem_ready) begin
        if (slave_cnt >= slave_wait) begin
          mem_ready = 1'b1;
          mem_rdata = slave_rdata;
          bus_n++;
          bus_addr  = mem_addr;
          bus_wdata = mem_wdata;
          bus_wstrb = mem_wstrb;
          slave_cnt = 0;
        end else begin
          slave_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        if (!mem_valid) slave_cnt = 0;
      end
    end
  end

  // UART transmit sink: holds wait for tx_wait cycles on every byte
  int         tx_wait = 0;
  int         tx_cnt = 0;
  bit         in_byte = 0;
  logic [7:0] held_di;
  int         di_unstable = 0;
  logic [7:0] rx_q [$];

  initial begin
    uart_dat_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_dat_we) begin
        if (!in_byte) begin
          in_byte = 1;
          held_di = uart_dat_di;
          tx_cnt  = 0;
        end else if (uart_dat_di !== held_di) begin
          di_unstable++;
        end
        if (tx_cnt < tx_wait) begin
          uart_dat_wait = 1'b1;
          tx_cnt++;
        end else begin
          uart_dat_wait = 1'b0;
          rx_q.push_back(uart_dat_di);
          in_byte = 0;
        end
      end else begin
        uart_dat_wait = 1'b0;
        in_byte = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    @(negedge clk);
    uart_dat_valid = 1'b1;
    uart_dat_do    = b;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      if (uart_dat_re) begin
        @(posedge clk);
        #1;
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    uart_dat_valid = 1'b0;
    chk("byte consumed", {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 3000 && busy; c++) @(negedge clk);
    @(negedge clk);
    chk("return to idle", {31'h0, busy}, 32'h0);
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    logic [7:0] got;
    v = vecs[idx];
    slave_wait   = v.swait;
    slave_rdata  = v.rdata;
    tx_wait      = v.twait;
    valid_cycles = 0;
    bus_n        = 0;
    di_unstable  = 0;
    rx_q.delete();
    for (int k = 0; k < v.n; k++) send_byte(v.bytes[8*k +: 8]);
    wait_idle();
    chk($sformatf("v%0d bus count", idx), bus_n, v.nbus);
    chk($sformatf("v%0d valid cycles", idx), valid_cycles, v.vcyc);
    if (v.nbus > 0) begin
      chk($sformatf("v%0d mem_addr", idx), bus_addr, v.eaddr);
      chk($sformatf("v%0d mem_wstrb", idx), {28'h0, bus_wstrb}, {28'h0, v.estrb});
      if (v.estrb == 4'hF) chk($sformatf("v%0d mem_wdata", idx), bus_wdata, v.ewdata);
    end
    chk($sformatf("v%0d reply len", idx), rx_q.size(), v.rlen);
    for (int k = 0; k < v.rlen; k++) begin
      got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
      chk($sformatf("v%0d reply byte %0d", idx, k), {24'h0, got}, {24'h0, v.reply[8*k +: 8]});
    end
    chk($sformatf("v%0d di stable", idx), di_unstable, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " mem_valid"}, {31'h0, mem_valid}, 32'h0);
    chk({tag, " busy"}, {31'h0, busy}, 32'h0);
    chk({tag, " we"}, {31'h0, uart_dat_we}, 32'h0);
    chk({tag, " di"}, {24'h0, uart_dat_di}, 32'h0);
    chk({tag, " mem_addr"}, mem_addr, 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, " mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
  endtask

  initial begin
    //          n  bytes (byte0 in LSBs)          rdata         sw tw nb eaddr         ewdata        strb vc rl reply
    vecs[0] = '{9, 72'hDEADBEEF_80000010_57,    32'h0,        0, 0, 1, 32'h80000010, 32'hDEADBEEF, 4'hF, 1, 1, 32'h4B};
    vecs[1] = '{5, 72'h00000004_52,             32'h12345678, 3, 0, 1, 32'h00000004, 32'h0,        4'h0, 4, 4, 32'h12345678};
    vecs[2] = '{1, 72'hA5,                      32'h0,        0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 1, 32'h3F};
    vecs[3] = '{5, 72'h00000103_52,             32'hA1B2C3D4, 0, 50, 1, 32'h00000100, 32'h0,       4'h0, 1, 4, 32'hA1B2C3D4};
    vecs[4] = '{9, 72'h04030201_FFFFFFFF_57,    32'h0,        2, 50, 1, 32'hFFFFFFFC, 32'h04030201, 4'hF, 3, 1, 32'h4B};
    vecs[5] = '{1, 72'h00,                      32'h0,        0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 1, 32'h3F};

    resetn = 1'b0;
    uart_dat_valid = 1'b0;
    uart_dat_do = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) apply_vec(i);

    // inter-byte timeout drops the packet silently
    bus_n = 0;
    rx_q.delete();
    tx_wait = 0;
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (50) @(negedge clk);
    chk("timeout still busy", {31'h0, busy}, 32'h1);
    repeat (70) @(negedge clk);
    chk("timeout idle", {31'h0, busy}, 32'h0);
    chk("timeout no bus", bus_n, 0);
    chk("timeout no reply", rx_q.size(), 0);
    apply_vec(1);

    // reset while the bus transaction is outstanding
    slave_wait = 10000;
    for (int k = 0; k < 9; k++) send_byte(vecs[0].bytes[8*k +: 8]);
    repeat (3) @(negedge clk);
    chk("mid-op mem_valid", {31'h0, mem_valid}, 32'h1);
    chk("mid-op mem_addr", mem_addr, 32'h80000010);
    uart_dat_do = 8'h52;
    uart_dat_valid = 1'b1;
    #1;
    chk("no consume in BUS", {31'h0, uart_dat_re}, 32'h0);
    #1;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    uart_dat_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("after reset");
    apply_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_dbg_bridge.md
# uart_dbg_bridge

Debug command bridge between `simpleuart`'s data register port and the system memory bus. It consumes received bytes, parses fixed-length read/write word commands, and issues one native-style (valid/ready) bus transaction per command. It then returns the response bytes through the same UART port. It is the host-side debug entry point of the SoC and sits directly downstream of the UART receiver and upstream of its transmitter.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: inter-byte timeout within a packet, in clk cycles.
- `clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `uart_dat_valid`  in  1  receive byte available.
- `uart_dat_do`  in  8  received byte (bits [7:0] of UART read data).
- `uart_dat_re`  out  1  consume the current receive byte.
- `uart_dat_we`  out  1  transmit request, held until accepted.
- `uart_dat_di`  out  8  transmit byte.
- `uart_dat_wait`  in  1  UART busy; the write is accepted in a cycle with `we && !wait`.
- `mem_valid`  out  1  bus request.
- `mem_ready`  in  1  bus completion.
- `mem_addr`  out  32  word address; bits [1:0] are forced to 0.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  0xF for a write, 0x0 for a read.
- `mem_rdata`  in  32  read data, valid when `mem_ready` is high.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Packet formats. All multi-byte fields are little-endian.
  - Write: `0x57`, 4 address bytes, 4 data bytes. Reply is one byte, `0x4B`.
  - Read: `0x52`, 4 address bytes. Reply is 4 rdata bytes.
  - Any other command byte: reply `0x3F`, return to IDLE.
- FSM states: IDLE, ADDR, DATA, BUS, RESP, ERR.
  - IDLE: when a byte is present, consume it. `0x57`/`0x52` latch the opcode and go to ADDR. Any other byte goes to ERR.
  - ADDR: consume 4 bytes into the address register, LSB first. Next state is DATA for a write, BUS for a read.
  - DATA: consume 4 bytes into the wdata register. Next state is BUS.
  - BUS: `mem_valid` is held high until `mem_ready`. A read latches `mem_rdata` into the response shift register. A write loads `0x4B`. Next state is RESP.
  - RESP: send 1 byte (write) or 4 bytes (read, LSB first). Next state is IDLE.
  - ERR: send `0x3F`, then go to IDLE.
- A 2-bit byte counter is shared by ADDR, DATA and RESP. It clears on every state entry and wraps 3 to 0 on the last byte.
- Timeout counter:
  - Counts only in ADDR and DATA.
  - Clears on every consumed byte and on state entry.
  - When it reaches `TIMEOUT_CYCLES-1`, the packet is dropped: go to IDLE, no reply, no bus access.
- Bytes arriving during BUS, RESP or ERR are not consumed; they stay in the UART buffer until the bridge reaches IDLE.
- There is no bus timeout; BUS waits for `mem_ready` indefinitely.

## Timing
- `uart_dat_re` is combinational: `uart_dat_valid && state ∈ {IDLE, ADDR, DATA}`. It is high in exactly the capture cycle; the UART drops valid on the following edge.
- `mem_valid` rises on the edge after the last command byte is consumed. `mem_addr`, `mem_wdata` and `mem_wstrb` are stable while `mem_valid` is high.
- `mem_valid` falls on the edge after the `mem_ready` cycle. A `mem_ready` in the first `mem_valid` cycle gives a one-cycle transaction.
- `uart_dat_we` and `uart_dat_di` are registered. `we` rises on the edge after entering RESP/ERR.
  - `we` and `di` hold while `uart_dat_wait` is high.
  - After an accepting cycle (`we && !wait`), the next byte is presented on the following edge; `we` stays high between bytes.
  - `we` falls on the edge after the final byte is accepted.
- Reset (async assert, sync deassert use) values:
  - state IDLE.
  - `uart_dat_we`, `mem_valid`, `busy` = 0.
  - `uart_dat_di` = 0; `mem_addr`, `mem_wdata` = 0; `mem_wstrb` = 0.
  - All counters 0.
  - Reset mid-transaction abandons it; the bus slave must tolerate a `mem_valid` drop.

## Structure
- Shared package `dbg_bridge_pkg`:
  - opcode constants `OP_WRITE` = `0x57`, `OP_READ` = `0x52`.
  - reply constants `RSP_ACK` = `0x4B`, `RSP_ERR` = `0x3F`.
  - FSM state enum.
- One natural sub-module, `dbg_byte_tx`. It holds the 32-bit response shift register, the byte counter and the `we`/`wait` handshake, and is loaded with (data, length 1..4).
- The parent holds the RX FSM, timeout and bus master.

## Test plan
- **Write command.** Bytes `57 10 00 00 80 EF BE AD DE` → one bus write: `mem_addr` = `0x80000010`, `mem_wdata` = `0xDEADBEEF`, `mem_wstrb` = `0xF`; then reply `0x4B`.
- **Read command.** Bytes `52 04 00 00 00`, slave returns `0x12345678` after 3 wait cycles → `mem_wstrb` = 0, `mem_valid` held for 4 cycles; reply `78 56 34 12` in order.
- **Unknown command.** Byte `0xA5` → no bus access, reply `0x3F`, `busy` low afterwards.
- **Inter-byte timeout.** Bytes `57 00 00`, then silence > `TIMEOUT_CYCLES` (bench sets 100) → return to IDLE, no reply. A following full read command then completes normally.
- **Backpressure.** `uart_dat_wait` held high for 50 cycles on each reply byte → `uart_dat_di` stable throughout, each byte sent exactly once.
- **Reset mid-operation.** `resetn` low while `mem_valid` is high → `mem_valid` 0 immediately (async). After release, the bridge is in IDLE with all outputs at reset values.
